// File: rtl/fpu_pkg.sv
// Shared FPU definitions: normaliser FSM states, IEEE-754 single constants.
package fpu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EVAL,
    SHIFT,
    ROUND,
    DONE
  } state_e;

  localparam int EXP_BIAS   = 127;
  localparam int EXP_MAX    = 255;
  localparam int FRAC_W     = 23;
  localparam int HIDDEN_BIT = 23;
  localparam int CARRY_BIT  = 24;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [30:0] INF_MAG   = {8'hFF, 23'h0};

  // Signed infinity in single precision.
  function automatic logic [31:0] inf_word(input logic sign);
    return {sign, INF_MAG};
  endfunction

endpackage

// File: rtl/fp_round_nearest_even.sv
// Round-to-nearest-even increment of a significand given its G/R/S bits.
module fp_round_nearest_even
  import fpu_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic [WORD_W-1:0] sig,
  input  logic              g,
  input  logic              r,
  input  logic              s,
  output logic [WORD_W-1:0] sig_rnd,
  output logic              carry,
  output logic              inexact
);

  logic inc;

  // Round up above half, or at exactly half when the LSB is odd.
  always_comb begin
    inc     = g & (r | s | sig[0]);
    sig_rnd = sig + {{(WORD_W-1){1'b0}}, inc};
    carry   = sig_rnd[CARRY_BIT];
    inexact = g | r | s;
  end

endmodule

// File: rtl/fp_norm_round_pack.sv
// Post-ALU stage: iterative normalisation, RNE rounding and single-precision packing.
module fp_norm_round_pack
  import fpu_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [WORD_W-1:0] in_sig,
  input  logic [2:0]        in_grs,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_result,
  output logic              out_overflow,
  output logic              out_inexact
);

  // Two guard bits of exponent headroom so overflow/underflow stay visible.
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] EXP_ONE = EW'(1);
  localparam logic signed [EW-1:0] EXP_LIM = EW'(EXP_MAX);

  state_e                 state_q, state_d;
  logic                   sign_q, sign_d;
  logic signed [EW-1:0]   exp_q, exp_d;
  logic [WORD_W-1:0]      sig_q, sig_d;
  logic                   g_q, g_d, r_q, r_d, s_q, s_d;
  logic                   out_valid_q, out_valid_d;
  logic [WORD_W-1:0]      out_result_q, out_result_d;
  logic                   out_overflow_q, out_overflow_d;
  logic                   out_inexact_q, out_inexact_d;

  logic [WORD_W-1:0]      rnd_sig;
  logic                   rnd_carry, rnd_inexact;
  logic [WORD_W-1:0]      fin_sig;
  logic signed [EW-1:0]   fin_exp;
  logic signed [EW-1:0]   exp_inc, exp_dec;
  logic [WORD_W-1:0]      shl_sig;
  logic                   unused_fin_hi;

  fp_round_nearest_even #(.WORD_W(WORD_W)) u_rne (
    .sig     (sig_q),
    .g       (g_q),
    .r       (r_q),
    .s       (s_q),
    .sig_rnd (rnd_sig),
    .carry   (rnd_carry),
    .inexact (rnd_inexact)
  );

  assign exp_inc = exp_q + EXP_ONE;
  assign exp_dec = exp_q - EXP_ONE;
  assign shl_sig = {sig_q[WORD_W-2:0], g_q};
  // A rounding carry into bit 24 renormalises by one right shift.
  assign fin_sig = rnd_carry ? (rnd_sig >> 1) : rnd_sig;
  assign fin_exp = rnd_carry ? exp_inc : exp_q;
  assign unused_fin_hi = ^fin_sig[WORD_W-1:HIDDEN_BIT+1];

  // Next-state and datapath for the normalise/round/pack sequence.
  always_comb begin
    state_d        = state_q;
    sign_d         = sign_q;
    exp_d          = exp_q;
    sig_d          = sig_q;
    g_d            = g_q;
    r_d            = r_q;
    s_d            = s_q;
    out_valid_d    = out_valid_q;
    out_result_d   = out_result_q;
    out_overflow_d = out_overflow_q;
    out_inexact_d  = out_inexact_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = in_sign;
          exp_d   = $signed({2'b00, in_exp});
          sig_d   = in_sig;
          {g_d, r_d, s_d} = in_grs;
          state_d = EVAL;
        end
      end
      EVAL: begin
        if (sig_q == '0 && {g_q, r_q, s_q} == 3'b000) begin
          out_result_d   = ZERO_WORD;
          out_overflow_d = 1'b0;
          out_inexact_d  = 1'b0;
          out_valid_d    = 1'b1;
          state_d        = DONE;
        end else if (sig_q[CARRY_BIT]) begin
          sig_d   = sig_q >> 1;
          exp_d   = exp_inc;
          g_d     = sig_q[0];
          r_d     = g_q;
          s_d     = r_q | s_q;
          state_d = ROUND;
        end else if (sig_q[HIDDEN_BIT] || exp_q <= EXP_ONE) begin
          state_d = ROUND;
        end else begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sig_d = shl_sig;
        g_d   = r_q;
        r_d   = 1'b0;
        exp_d = exp_dec;
        // Stop on a normalised hidden bit or at the denormal exponent floor.
        if (shl_sig[HIDDEN_BIT] || exp_dec <= EXP_ONE) state_d = ROUND;
      end
      ROUND: begin
        out_valid_d   = 1'b1;
        out_inexact_d = rnd_inexact;
        if (fin_exp >= EXP_LIM) begin
          out_result_d   = inf_word(sign_q);
          out_overflow_d = 1'b1;
        end else begin
          out_overflow_d = 1'b0;
          out_result_d   = {sign_q,
                            fin_sig[HIDDEN_BIT] ? fin_exp[EXP_W-1:0] : {EXP_W{1'b0}},
                            fin_sig[FRAC_W-1:0]};
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      sign_q         <= 1'b0;
      exp_q          <= '0;
      sig_q          <= '0;
      g_q            <= 1'b0;
      r_q            <= 1'b0;
      s_q            <= 1'b0;
      out_valid_q    <= 1'b0;
      out_result_q   <= '0;
      out_overflow_q <= 1'b0;
      out_inexact_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      sign_q         <= sign_d;
      exp_q          <= exp_d;
      sig_q          <= sig_d;
      g_q            <= g_d;
      r_q            <= r_d;
      s_q            <= s_d;
      out_valid_q    <= out_valid_d;
      out_result_q   <= out_result_d;
      out_overflow_q <= out_overflow_d;
      out_inexact_q  <= out_inexact_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = out_valid_q;
  assign out_result   = out_result_q;
  assign out_overflow = out_overflow_q;
  assign out_inexact  = out_inexact_q;

endmodule

// File: tb/tb_fp_norm_round_pack.sv
// Directed + random bench for fp_norm_round_pack against a value-level rounding model.
module tb_fp_norm_round_pack;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = '0;
  logic [31:0] in_sig = '0;
  logic [2:0]  in_grs = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_inexact;

  int checks = 0;
  int errors = 0;

  fp_norm_round_pack #(.EXP_W(8), .FRAC_W(23), .WORD_W(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sign      (in_sign),
    .in_exp       (in_exp),
    .in_sig       (in_sig),
    .in_grs       (in_grs),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_overflow (out_overflow),
    .out_inexact  (out_inexact)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Value-level model: exact part Y = sig*4 + 2G + R, plus a sticky epsilon.
  // Pick the output exponent from Y's leading one (clamped at 1 for denormals),
  // drop t bits of Y, round to nearest even, renormalise, then pack.
  function automatic void ref_model(input bit s, input int e, input longint sg,
                                    input bit [2:0] grs, output logic [31:0] res,
                                    output bit ovf, output bit inx, output int cyc);
    longint y, q, rem, half;
    bit st, up;
    int p, en, k, t;
    logic [7:0] ef;
    y  = sg * 4 + longint'(grs[2]) * 2 + longint'(grs[1]);
    st = grs[0];
    p  = -1;
    up = 0;
    if (y == 0 && !st) begin
      res = 32'h0; ovf = 0; inx = 0; cyc = 1;
      return;
    end
    if (y == 0) begin
      res = {s, 31'h0}; ovf = 0; inx = 1;
      cyc = 2 + ((e > 1) ? e - 1 : 0);
      return;
    end
    for (int i = 0; i < 40; i++) if (y[i]) p = i;
    en = e + p - 25;
    if (en < 1) en = 1;
    k = (p < 25) ? e - en : 0;
    t = 2 + en - e;
    if (t <= 0) begin
      q   = y << (-t);
      inx = st;
    end else begin
      q    = y >> t;
      rem  = y & ((longint'(1) << t) - 1);
      half = longint'(1) << (t - 1);
      up   = (rem > half) || (rem == half && (st || q[0]));
      inx  = (rem != 0) || st;
    end
    if (up) q = q + 1;
    if (q >= (longint'(1) << 24)) begin
      q  = q >> 1;
      en = en + 1;
    end
    if (en >= 255) begin
      res = {s, 8'hFF, 23'h0};
      ovf = 1;
    end else begin
      ef  = (q >= (longint'(1) << 23)) ? en[7:0] : 8'h00;
      res = {s, ef, q[22:0]};
      ovf = 0;
    end
    cyc = 2 + k;
  endfunction

  // One full transaction: offer, accept, wait for result, optional backpressure, handshake.
  task automatic run_txn(input string tag, input bit s, input int e, input logic [31:0] sg,
                         input bit [2:0] grs, input int hold);
    logic [31:0] er;
    bit eo, ei, busy_rdy, unstable;
    int ecyc, cyc;
    ref_model(s, e, longint'(sg), grs, er, eo, ei, ecyc);
    out_ready = (hold == 0);
    @(negedge clk);
    chk({tag, " in_ready_idle"}, {31'h0, in_ready}, 32'h1);
    in_valid = 1'b1; in_sign = s; in_exp = e[7:0]; in_sig = sg; in_grs = grs;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0; busy_rdy = 0;
    while (out_valid !== 1'b1 && cyc < 100) begin
      if (in_ready !== 1'b0) busy_rdy = 1;
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, " out_valid_seen"}, {31'h0, out_valid}, 32'h1);
    if (out_valid !== 1'b1) begin
      out_ready = 1'b1;
      return;
    end
    chk({tag, " latency"}, cyc, ecyc);
    chk({tag, " in_ready_busy"}, {31'h0, busy_rdy | in_ready}, 32'h0);
    chk({tag, " result"}, out_result, er);
    chk({tag, " overflow"}, {31'h0, out_overflow}, {31'h0, eo});
    chk({tag, " inexact"}, {31'h0, out_inexact}, {31'h0, ei});
    unstable = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out_result !== er || out_overflow !== eo ||
          out_inexact !== ei || in_ready !== 1'b0) unstable = 1;
    end
    if (hold > 0) chk({tag, " hold_stable"}, {31'h0, unstable}, 32'h0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, " valid_drop"}, {31'h0, out_valid}, 32'h0);
    chk({tag, " ready_back"}, {31'h0, in_ready}, 32'h1);
    $display("txn %s: sign=%0d exp=%0d sig=%h grs=%b -> result=%h ovf=%0d inx=%0d valid@N+%0d (model %h/%0d/%0d)",
             tag, s, e, sg, grs, er, eo, ei, cyc + 1, er, eo, ei);
  endtask

  initial begin
    bit seen;
    int w, sel, ev;
    logic [31:0] sgr;

    // Reset state
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", {31'h0, out_valid}, 32'h0);
    chk("reset out_result", out_result, 32'h0);
    chk("reset out_overflow", {31'h0, out_overflow}, 32'h0);
    chk("reset out_inexact", {31'h0, out_inexact}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("reset in_ready", {31'h0, in_ready}, 32'h1);

    // Directed cases
    run_txn("one",        0, 127, 32'h0080_0000, 3'b000, 0);
    run_txn("carry",      0, 127, 32'h0100_0000, 3'b000, 0);
    run_txn("carry_ovf",  0, 254, 32'h0100_0000, 3'b000, 0);
    run_txn("shift15",    0, 127, 32'h0000_0100, 3'b000, 0);
    run_txn("tie_up",     0, 127, 32'h00FF_FFFF, 3'b100, 0);
    run_txn("denorm",     0,   3, 32'h0000_0001, 3'b000, 0);
    run_txn("neg_zero",   1, 127, 32'h0000_0000, 3'b000, 0);
    run_txn("tie_even",   1, 100, 32'h0080_0002, 3'b100, 0);
    run_txn("sticky_only",0,   5, 32'h0000_0000, 3'b001, 0);
    run_txn("denorm_up",  0,   1, 32'h007F_FFFF, 3'b110, 0);
    run_txn("backpress",  0, 127, 32'h00C0_0000, 3'b011, 5);

    // Reset during SHIFT aborts the operation
    @(negedge clk);
    in_valid = 1'b1; in_sign = 0; in_exp = 8'd127; in_sig = 32'h0000_0100; in_grs = 3'b000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("abort out_valid", {31'h0, out_valid}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("abort in_ready", {31'h0, in_ready}, 32'h1);
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      if (out_valid !== 1'b0) seen = 1;
      @(posedge clk); #1;
    end
    chk("abort no_result", {31'h0, seen}, 32'h0);
    $display("txn abort: reset during SHIFT, out_valid stayed low, in_ready=%0d", in_ready);

    // Random operands across exponent extremes and significand magnitudes
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 3);
      if (sel == 0)      ev = $urandom_range(1, 4);
      else if (sel == 1) ev = $urandom_range(250, 254);
      else               ev = $urandom_range(1, 254);
      w = $urandom_range(0, 25);
      if (w == 0) sgr = 32'h0;
      else sgr = ($urandom & ((32'h1 << w) - 32'h1)) | ((sel == 3) ? 32'h0 : (32'h1 << (w - 1)));
      run_txn($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), ev, sgr,
              3'($urandom_range(0, 7)), $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
